// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ==== fifo_rd_pkg : shared state encoding and sizing helper for the FIFO stream reader ====
// ==== rev 1.0 ====
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } rd_state_t;

  // Beat counter needs at least one bit even for single-word bursts.
  function automatic int beat_width(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ==== fifo_rd_skid : 2-entry skid buffer popping a FWFT FIFO onto a valid/ready stream ====
// ==== rev 1.0 ====
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  pop
);

  rd_state_t             state;
  logic [DATA_WIDTH-1:0] e1;

  // Popping depends only on buffer occupancy, never on m_ready.
  assign fifo_rd_en = rd_rst_n & ~fifo_empty & (state != S_TWO);
  assign pop        = m_valid & m_ready;

  // m_data is the head entry e0 itself.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state   <= S_EMPTY;
      m_valid <= 1'b0;
      m_data  <= '0;
      e1      <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (fifo_rd_en) begin
            state   <= S_ONE;
            m_valid <= 1'b1;
            m_data  <= fifo_rd_data;
          end
        end
        S_ONE: begin
          if (fifo_rd_en && !pop) begin
            state <= S_TWO;
            e1    <= fifo_rd_data;
          end else if (!fifo_rd_en && pop) begin
            state   <= S_EMPTY;
            m_valid <= 1'b0;
          end else if (fifo_rd_en && pop) begin
            m_data <= fifo_rd_data;
          end
        end
        S_TWO: begin
          if (pop) begin
            state  <= S_ONE;
            m_data <= e1;
          end
        end
        default: begin
          state   <= S_EMPTY;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ==== fifo_stream_reader : FIFO read-side stream consumer with word counter; optional
// ==== burst framing on m_last when FIFO_RD_LAST_EN is defined.  rev 1.0 ====
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  rd_word_cnt
);

  logic pop;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .pop          (pop)
  );

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      rd_word_cnt <= '0;
    end else if (pop) begin
      rd_word_cnt <= rd_word_cnt + 1'b1;
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int                BEAT_W    = beat_width(BURST_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat;

  // beat tracks the position of the word currently at the head of the stream.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      beat <= '0;
    end else if (pop) begin
      beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
    end
  end

  assign m_last = m_valid & (beat == BEAT_LAST);
`else
  logic unused_burst_len;
  assign unused_burst_len = (BURST_LEN > 0);
  assign m_last           = 1'b0;
`endif

endmodule
`default_nettype wire
